// File: rtl/motion_sequencer_pkg.sv
// Package: motion_pkg
// Purpose : shared definitions for the motion sequencer slice: command opcodes,
//           FSM state encoding and helpers locating the fields inside cmd_data.
// Contents: OP_STOP/OP_DRIVE/OP_SPIN/OP_RSVD, state_t, cmd_dir_bit(), cmd_op_lsb().
package motion_pkg;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_DRIVE = 2'b01;
    localparam logic [1:0] OP_SPIN  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // cmd_data layout: {opcode[1:0], dir, count[count_w-1:0]}
    function automatic int cmd_dir_bit(input int count_w);
        return count_w;
    endfunction

    function automatic int cmd_op_lsb(input int count_w);
        return count_w + 1;
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Interface: motion_sequencer_if
// Purpose  : command channel from the dispatcher into the motion sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
//            cmd_ready are both 1. The master holds cmd_data/input_speed stable
//            while cmd_valid is 1; the slave raises cmd_ready only when it can
//            take a new command, and nothing is queued.
// Signals  : cmd_valid, cmd_ready, cmd_data[COUNT_W+2:0], input_speed[SPEED_W-1:0]
// Modports : master (dispatcher side), slave (sequencer side)
interface motion_sequencer_if #(
    parameter int COUNT_W = 8,
    parameter int SPEED_W = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COUNT_W+2:0] cmd_data;
    logic [SPEED_W-1:0] input_speed;

    modport master (
        output cmd_valid,
        output cmd_data,
        output input_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  input_speed,
        output cmd_ready
    );
endinterface

// File: rtl/motion_sequencer_speed_ramp.sv
// Module : speed_ramp
// Purpose: linear speed ramp. A prescaler produces one step every RAMP_DIV
//          clocks; each step moves speed one LSB up toward target (dir_up=1)
//          or down toward zero (dir_up=0), saturating at either end.
// Ports  : clk, rst (sync, active-low), clr (restart prescaler), dir_up,
//          target[SPEED_W-1:0] -> speed[SPEED_W-1:0], at_target
module speed_ramp #(
    parameter int SPEED_W  = 3,
    parameter int RAMP_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               dir_up,
    input  logic [SPEED_W-1:0] target,
    output logic [SPEED_W-1:0] speed,
    output logic               at_target
);
    localparam int            PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

    logic [PW-1:0] presc_q;
    logic          step;

    assign step = (presc_q == PRESC_LAST);

    // clr wins over a coincident step so the first step after a state
    // change always lands a full RAMP_DIV clocks later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            speed   <= '0;
        end else if (clr) begin
            presc_q <= '0;
        end else begin
            presc_q <= step ? '0 : presc_q + 1'b1;
            if (step) begin
                if (dir_up && (speed < target)) begin
                    speed <= speed + 1'b1;
                end else if (!dir_up && (speed != '0)) begin
                    speed <= speed - 1'b1;
                end
            end
        end
    end

    assign at_target = dir_up ? (speed == target) : (speed == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Module : motion_sequencer
// Purpose: two-wheel motion sequencer. Accepts STOP/DRIVE/SPIN commands,
//          ramps both wheels to the commanded speed, counts encoder ticks
//          down to zero (or stops on abort), ramps back to zero and pulses done.
// Ports  : clk, rst (sync, active-low)
//          cmd (motion_sequencer_if.slave): cmd_valid, cmd_ready, cmd_data, input_speed
//          tick, abort                      : encoder pulse, early-stop request
//          speed_wheel1/2, dir_wheel1/2     : wheel drive outputs (0=fwd 1=rev)
//          remaining, busy, done, err_opcode: status
//          state_dbg                        : current FSM state
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int SPEED_W  = 3,
    parameter int COUNT_W  = 8,
    parameter int RAMP_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    motion_sequencer_if.slave  cmd,
    input  logic               tick,
    input  logic               abort,
    output logic [SPEED_W-1:0] speed_wheel1,
    output logic [SPEED_W-1:0] speed_wheel2,
    output logic               dir_wheel1,
    output logic               dir_wheel2,
    output logic [COUNT_W-1:0] remaining,
    output logic               busy,
    output logic               done,
    output logic               err_opcode,
    output state_t             state_dbg
);
    state_t             state_q, state_d;
    logic [SPEED_W-1:0] target_q;
    logic [COUNT_W-1:0] rem_q;
    logic               dir1_q, dir2_q, err_q;

    logic [1:0]         cmd_op;
    logic               cmd_dir;
    logic [COUNT_W-1:0] cmd_cnt;
    logic               accept;
    logic               starts_motion;
    logic               final_tick;

    logic [SPEED_W-1:0] speed;
    logic               at_target;
    logic               ramp_clr;
    logic               ramp_up;

    assign cmd_op  = cmd.cmd_data[cmd_op_lsb(COUNT_W) +: 2];
    assign cmd_dir = cmd.cmd_data[cmd_dir_bit(COUNT_W)];
    assign cmd_cnt = cmd.cmd_data[COUNT_W-1:0];

    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign starts_motion = ((cmd_op == OP_DRIVE) || (cmd_op == OP_SPIN)) && (cmd_cnt != '0);
    assign final_tick    = tick && (rem_q == COUNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_d       = state_q;
        cmd.cmd_ready = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (accept) begin
                    state_d = starts_motion ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort || final_tick) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                // ramp runs downward here, so at_target means speed == 0
                if (at_target) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command register, tick counter and direction mapping
    always_ff @(posedge clk) begin
        if (!rst) begin
            target_q <= '0;
            rem_q    <= '0;
            dir1_q   <= 1'b0;
            dir2_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                target_q <= cmd.input_speed;
                rem_q    <= cmd_cnt;
                err_q    <= (cmd_op == OP_RSVD);
                // STOP and reserved opcodes carry no direction; wheels keep theirs
                if (cmd_op == OP_DRIVE) begin
                    dir1_q <= cmd_dir;
                    dir2_q <= cmd_dir;
                end else if (cmd_op == OP_SPIN) begin
                    dir1_q <= cmd_dir;
                    dir2_q <= ~cmd_dir;
                end
            end else if ((state_q == ST_RUN) && tick && (rem_q != '0)) begin
                rem_q <= rem_q - 1'b1;
            end
        end
    end

    assign ramp_clr = (state_d != state_q);
    assign ramp_up  = (state_q == ST_RUN);

    speed_ramp #(
        .SPEED_W  (SPEED_W),
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .clr       (ramp_clr),
        .dir_up    (ramp_up),
        .target    (target_q),
        .speed     (speed),
        .at_target (at_target)
    );

    assign speed_wheel1 = speed;
    assign speed_wheel2 = speed;
    assign dir_wheel1   = dir1_q;
    assign dir_wheel2   = dir2_q;
    assign remaining    = rem_q;
    assign err_opcode   = err_q;
    assign state_dbg    = state_q;

endmodule
